lc3_bus_arbiter: RTL

Round-robin arbiter that shares the LC-3 internal bus between four gated sources (PC, MDR, ALU, MARMUX), which the datapath selects through a 4:1 bus multiplexer. It takes one level-sensitive request per source, grants at most one source at a time, and drives the registered multiplexer select together with a one-hot grant vector. A hold limit bounds how long one owner keeps the bus while others wait.

---
 rtl/lc3_bus_pkg.sv | 26 ++
 rtl/lc3_bus_arbiter_rr_pick.sv | 25 ++
 rtl/lc3_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lc3_bus_pkg.sv
// Shared types and constants for the LC-3 internal bus arbiter.
// Source indices match the select encoding of the 4:1 bus multiplexer.
package lc3_bus_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] bus_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam bus_sel_t SRC_PC     = 2'd0;
    localparam bus_sel_t SRC_MDR    = 2'd1;
    localparam bus_sel_t SRC_ALU    = 2'd2;
    localparam bus_sel_t SRC_MARMUX = 2'd3;

    function automatic logic [N_REQ-1:0] sel_to_onehot(input bus_sel_t i_idx);
        logic [N_REQ-1:0] v;
        v        = 4'b0000;
        v[i_idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/lc3_bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request in the order
// base+1, base+2, base+3, base (mod 4).
module rr_pick
    import lc3_bus_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  bus_sel_t         base,
    output logic             found,
    output bus_sel_t         idx
);

    bus_sel_t w_cand;

    // Scan from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        w_cand = base;
        idx    = base;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = base + bus_sel_t'(k);
            idx    = req[w_cand] ? w_cand : idx;
        end
        found = |req;
    end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// Round-robin arbiter for the four LC-3 bus sources with a bounded hold time
// under contention; grant, select and busy are all registered.
module lc3_bus_arbiter
    import lc3_bus_pkg::bus_sel_t;
    import lc3_bus_pkg::arb_state_t;
    import lc3_bus_pkg::IDLE;
    import lc3_bus_pkg::GRANT;
    import lc3_bus_pkg::SRC_PC;
    import lc3_bus_pkg::SRC_MARMUX;
    import lc3_bus_pkg::sel_to_onehot;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       sel,
    output logic             busy
);

    if (N_REQ != 4) begin : g_bad_n_req
        $error("lc3_bus_arbiter: N_REQ must be 4");
    end
    if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
        $error("lc3_bus_arbiter: MAX_HOLD must be in 2..256");
    end

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t       r_state,    w_state;
    logic [3:0]       r_gnt,      w_gnt;
    bus_sel_t         r_sel,      w_sel;
    logic             r_busy,     w_busy;
    bus_sel_t         r_last,     w_last;
    logic [HW-1:0]    r_hold_cnt, w_hold;

    logic             w_found;
    bus_sel_t         w_idx;
    logic [3:0]       w_owner_mask;
    logic             w_owner_req;
    logic             w_others;
    logic             w_take;
    logic             w_drop;

    rr_pick u_pick (
        .req   (req),
        .base  (r_last),
        .found (w_found),
        .idx   (w_idx)
    );

    // Next-state logic: decide whether to hand the bus over, drop it, or keep it.
    always_comb begin
        w_state      = r_state;
        w_gnt        = r_gnt;
        w_sel        = r_sel;
        w_busy       = r_busy;
        w_last       = r_last;
        w_hold       = r_hold_cnt;
        w_take       = 1'b0;
        w_drop       = 1'b0;
        w_owner_mask = sel_to_onehot(r_last);
        w_owner_req  = |(req & w_owner_mask);
        w_others     = |(req & ~w_owner_mask);

        case (r_state)
            IDLE: begin
                w_take = w_found;
                w_drop = ~w_found;
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_take = w_found;
                    w_drop = ~w_found;
                end else if (w_others) begin
                    // Forced handoff: the picker never returns the owner here.
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_take = 1'b1;
                    end else begin
                        w_hold = r_hold_cnt + HW'(1);
                    end
                end else begin
                    if (r_hold_cnt != HOLD_LAST) begin
                        w_hold = r_hold_cnt + HW'(1);
                    end else begin
                        w_hold = r_hold_cnt;
                    end
                end
            end
            default: begin
                w_drop = 1'b1;
            end
        endcase

        if (w_take) begin
            w_state = GRANT;
            w_gnt   = sel_to_onehot(w_idx);
            w_sel   = w_idx;
            w_busy  = 1'b1;
            w_last  = w_idx;
            w_hold  = '0;
        end else if (w_drop) begin
            w_state = IDLE;
            w_gnt   = 4'b0000;
            w_busy  = 1'b0;
        end else begin
            w_state = r_state;
        end
    end

    // State and output registers; last starts at MARMUX so PC wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= SRC_PC;
            r_busy     <= 1'b0;
            r_last     <= SRC_MARMUX;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_sel      <= w_sel;
            r_busy     <= w_busy;
            r_last     <= w_last;
            r_hold_cnt <= w_hold;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
